// File: rtl/display_mode_sequencer.sv
// Frame-synchronous display-mode latch and ping-pong histogram bank sequencer.
// Optional per-frame pixel-count check: define DMS_PIXCOUNT_CHECK_EN.
module display_mode_sequencer #(
  parameter int unsigned NUM_BINS = 256,
  parameter int unsigned BIN_AW   = 8,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic              CCD_PIXCLK,
  input  logic              iRst,
  input  logic [17:0]       iDisplaySelect,
  input  logic              iFval,
  input  logic              iCCD_DVAL,
  output logic [2:0]        oMode,
  output logic              oHistBank,
  output logic              oHistClr,
  output logic [BIN_AW-1:0] oHistClrAddr,
  output logic              oHistAccum,
  output logic              oStatsValid,
  output logic              oClrOverrun,
  output logic              oFrameStart,
  output logic [15:0]       oFrameCnt,
  output logic              oFrameErr
);

  localparam int unsigned PIX_W = 19;
  localparam logic [BIN_AW-1:0] LAST_ADDR = BIN_AW'(NUM_BINS - 1);

  typedef enum logic [1:0] {ST_CLEAR, ST_WAIT, ST_ACTIVE} state_t;

  state_t            state, state_nxt;
  logic              fval_d;
  logic              clean, clean_nxt;
  logic [2:0]        mode_dec, mode_nxt;
  logic              bank_nxt, clr_nxt, sv_nxt, ovr_nxt;
  logic [BIN_AW-1:0] addr_nxt;
  logic [15:0]       cnt_nxt;
  logic              rise, fall, is_hist, pix_ok;

  assign rise    = iFval & ~fval_d;
  assign fall    = ~iFval & fval_d;
  assign is_hist = (oMode == 3'd2) || (oMode == 3'd3);

  assign oHistAccum  = iCCD_DVAL & is_hist &
                       (((state == ST_ACTIVE) & iFval) | ((state != ST_ACTIVE) & rise));
  assign oFrameStart = rise & (state != ST_ACTIVE);

  // Switch priority decode; bits 0, 1, 6 and 9-17 never select a mode.
  always_comb begin
    mode_dec = 3'd0;
    if      (iDisplaySelect[8]) mode_dec = 3'd6;
    else if (iDisplaySelect[7]) mode_dec = 3'd5;
    else if (iDisplaySelect[5]) mode_dec = 3'd4;
    else if (iDisplaySelect[4]) mode_dec = 3'd3;
    else if (iDisplaySelect[3]) mode_dec = 3'd2;
    else if (iDisplaySelect[2]) mode_dec = 3'd1;
  end

  logic unused_sel;
  assign unused_sel = ^{iDisplaySelect[17:9], iDisplaySelect[6], iDisplaySelect[1:0]};

  always_ff @(posedge CCD_PIXCLK) begin
    if (iRst) begin
      state        <= ST_CLEAR;
      fval_d       <= 1'b1;
      clean        <= 1'b0;
      oMode        <= 3'd0;
      oHistBank    <= 1'b0;
      oHistClr     <= 1'b0;
      oHistClrAddr <= '0;
      oStatsValid  <= 1'b0;
      oClrOverrun  <= 1'b0;
      oFrameCnt    <= 16'd0;
    end else begin
      state        <= state_nxt;
      fval_d       <= iFval;
      clean        <= clean_nxt;
      oMode        <= mode_nxt;
      oHistBank    <= bank_nxt;
      oHistClr     <= clr_nxt;
      oHistClrAddr <= addr_nxt;
      oStatsValid  <= sv_nxt;
      oClrOverrun  <= ovr_nxt;
      oFrameCnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clean_nxt = clean;
    mode_nxt  = oMode;
    bank_nxt  = oHistBank;
    clr_nxt   = oHistClr;
    addr_nxt  = oHistClrAddr;
    sv_nxt    = oStatsValid;
    ovr_nxt   = oClrOverrun;
    cnt_nxt   = oFrameCnt;

    // Mode only follows the switches while no frame is in flight.
    if (!iFval && (state != ST_ACTIVE)) mode_nxt = mode_dec;

    unique case (state)
      ST_CLEAR: begin
        if (rise) begin
          state_nxt = ST_ACTIVE;
          clr_nxt   = 1'b0;
          ovr_nxt   = 1'b1;
          clean_nxt = 1'b0;
        end else if (!oHistClr) begin
          clr_nxt = 1'b1;
        end else if (oHistClrAddr == LAST_ADDR) begin
          clr_nxt   = 1'b0;
          state_nxt = ST_WAIT;
        end else begin
          addr_nxt = oHistClrAddr + BIN_AW'(1);
        end
      end
      ST_WAIT: begin
        if (rise) begin
          state_nxt = ST_ACTIVE;
          clean_nxt = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (fall) begin
          state_nxt = ST_CLEAR;
          bank_nxt  = ~oHistBank;
          sv_nxt    = is_hist & clean & pix_ok;
          cnt_nxt   = oFrameCnt + 16'd1;
          clr_nxt   = 1'b1;
          addr_nxt  = '0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

`ifdef DMS_PIXCOUNT_CHECK_EN
  logic [PIX_W-1:0] pix_cnt;

  assign pix_ok = (pix_cnt == PIX_W'(H_ACTIVE * V_ACTIVE));

  // Counting starts on the rise cycle so the first pixel is included.
  always_ff @(posedge CCD_PIXCLK) begin
    if (iRst) begin
      pix_cnt   <= '0;
      oFrameErr <= 1'b0;
    end else begin
      if (rise && (state != ST_ACTIVE))
        pix_cnt <= PIX_W'(iCCD_DVAL);
      else if ((state == ST_ACTIVE) && iFval && iCCD_DVAL)
        pix_cnt <= pix_cnt + PIX_W'(1);
      if ((state == ST_ACTIVE) && fall)
        oFrameErr <= ~pix_ok;
    end
  end
`else
  logic unused_geom;
  assign unused_geom = ^(PIX_W'(H_ACTIVE * V_ACTIVE));
  assign pix_ok      = 1'b1;
  assign oFrameErr   = 1'b0;
`endif

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Directed self-checking bench for display_mode_sequencer (reduced 8x4 frame geometry).
module tb_display_mode_sequencer;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int NB = 256;
  localparam int AW = 8;
  localparam int NPIX = H * V;

`ifdef DMS_PIXCOUNT_CHECK_EN
  localparam logic SV_DROP   = 1'b0;
  localparam logic FERR_DROP = 1'b1;
`else
  localparam logic SV_DROP   = 1'b1;
  localparam logic FERR_DROP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [17:0]   sel;
  logic          fval;
  logic          dval;
  logic [2:0]    mode;
  logic          hist_bank;
  logic          hist_clr;
  logic [AW-1:0] hist_clr_addr;
  logic          hist_accum;
  logic          stats_valid;
  logic          clr_overrun;
  logic          frame_start;
  logic [15:0]   frame_cnt;
  logic          frame_err;

  int checks   = 0;
  int failures = 0;
  int accum_cnt = 0;
  int clr_total = 0;
  int clr_run   = 0;
  int addr_bad  = 0;
  int exp_cnt   = 0;
  logic exp_bank = 1'b0;

  always #5 clk = ~clk;

  display_mode_sequencer #(
    .NUM_BINS(NB), .BIN_AW(AW), .H_ACTIVE(H), .V_ACTIVE(V)
  ) dut (
    .CCD_PIXCLK(clk), .iRst(rst), .iDisplaySelect(sel), .iFval(fval),
    .iCCD_DVAL(dval), .oMode(mode), .oHistBank(hist_bank), .oHistClr(hist_clr),
    .oHistClrAddr(hist_clr_addr), .oHistAccum(hist_accum), .oStatsValid(stats_valid),
    .oClrOverrun(clr_overrun), .oFrameStart(frame_start), .oFrameCnt(frame_cnt),
    .oFrameErr(frame_err)
  );

  // Mid-cycle observer: accumulate strobes and clear-address sequence.
  always @(negedge clk) begin
    if (hist_accum) accum_cnt++;
    if (hist_clr) begin
      if (hist_clr_addr !== AW'(clr_run)) addr_bad++;
      clr_run++;
      clr_total++;
    end else begin
      clr_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic blank(input int n);
    fval = 1'b0;
    dval = 1'b0;
    step(n);
  endtask

  task automatic lines(input int n, input int drop);
    for (int l = 0; l < n; l++) begin
      for (int c = 0; c < H + 2; c++) begin
        fval = 1'b1;
        dval = (c < H) && ((l * H + c) != drop);
        step(1);
      end
    end
  endtask

  task automatic end_frame(input string tag, input logic sv);
    fval = 1'b0;
    dval = 1'b0;
    step(1);
    exp_bank = ~exp_bank;
    exp_cnt++;
    check({tag, "_bank"}, hist_bank, exp_bank);
    check({tag, "_fcnt"}, frame_cnt, exp_cnt);
    check({tag, "_sv"}, stats_valid, sv);
    check({tag, "_clr"}, hist_clr, 1);
    check({tag, "_clraddr"}, hist_clr_addr, 0);
  endtask

  task automatic frame(input string tag, input int blank_n, input int drop,
                       input logic sv, input int acc);
    int a0;
    blank(blank_n);
    a0 = accum_cnt;
    lines(V, drop);
    check({tag, "_accum"}, accum_cnt - a0, acc);
    end_frame(tag, sv);
  endtask

  logic [17:0] dec_sel [9];
  logic [2:0]  dec_exp [9];
  int c0;

  initial begin
    rst = 1'b1; sel = '0; fval = 1'b0; dval = 1'b0;
    step(3);
    check("rst_mode", mode, 0);
    check("rst_bank", hist_bank, 0);
    check("rst_clr", hist_clr, 0);
    check("rst_addr", hist_clr_addr, 0);
    check("rst_sv", stats_valid, 0);
    check("rst_ovr", clr_overrun, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_ferr", frame_err, 0);

    c0 = clr_total;
    rst = 1'b0;
    step(1);
    check("clr_first", hist_clr, 1);
    check("clr_first_addr", hist_clr_addr, 0);
    step(299);
    check("clr_len", clr_total - c0, NB);
    check("clr_addr_seq", addr_bad, 0);
    check("clr_done", hist_clr, 0);
    check("clr_bank", hist_bank, 0);
    check("clr_mode", mode, 0);

    // Mode latched at frame boundaries only.
    sel = 18'(1 << 5);
    step(2);
    fval = 1'b1; dval = 1'b1;
    #1;
    check("fb_start", frame_start, 1);
    check("fb_mode_first", mode, 4);
    lines(2, -1);
    check("fb_mode_mid", mode, 4);
    sel = 18'(1 << 2);
    lines(2, -1);
    check("fb_mode_end", mode, 4);
    end_frame("fb1", 1'b0);
    blank(300);
    check("fb_mode_blank", mode, 1);
    fval = 1'b1; dval = 1'b1;
    #1;
    check("fb_mode_next", mode, 1);
    lines(V, -1);
    end_frame("fb2", 1'b0);

    dec_sel[0] = 18'((1 << 8) | (1 << 3));         dec_exp[0] = 3'd6;
    dec_sel[1] = 18'(1 << 1);                      dec_exp[1] = 3'd0;
    dec_sel[2] = 18'(1 << 6);                      dec_exp[2] = 3'd0;
    dec_sel[3] = 18'd0;                            dec_exp[3] = 3'd0;
    dec_sel[4] = 18'(1 << 7);                      dec_exp[4] = 3'd5;
    dec_sel[5] = 18'(1 << 4);                      dec_exp[5] = 3'd3;
    dec_sel[6] = 18'((1 << 17) | (1 << 9) | 1);    dec_exp[6] = 3'd0;
    dec_sel[7] = 18'((1 << 5) | (1 << 2));         dec_exp[7] = 3'd4;
    dec_sel[8] = 18'((1 << 3) | (1 << 2) | 2);     dec_exp[8] = 3'd2;
    for (int i = 0; i < 9; i++) begin
      sel = dec_sel[i];
      step(2);
      check($sformatf("dec%0d", i), mode, dec_exp[i]);
    end

    // Switch change on the rise cycle must not affect this frame.
    sel = '0;
    step(300);
    sel = 18'(1 << 3); fval = 1'b1; dval = 1'b1;
    step(1);
    check("same_cyc_mode", mode, 0);
    lines(V, -1);
    end_frame("sc", 1'b0);

    frame("h1", 300, -1, 1'b1, NPIX);
    frame("h2", 300, -1, 1'b1, NPIX);
    sel = 18'(1 << 2);
    frame("h3", 300, -1, 1'b0, 0);

    sel = 18'(1 << 3);
    check("ovr_pre", clr_overrun, 0);
    frame("o1", 100, -1, 1'b0, NPIX);
    check("ovr_set", clr_overrun, 1);
    frame("o2", 300, -1, 1'b1, NPIX);
    check("ovr_sticky", clr_overrun, 1);

    frame("p1", 300, 5, SV_DROP, NPIX - 1);
    check("pix_ferr", frame_err, FERR_DROP);
    frame("p2", 300, -1, 1'b1, NPIX);
    check("pix_ferr_ok", frame_err, 0);

    // Reset in the middle of a frame discards it.
    blank(300);
    lines(2, -1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    lines(2, -1);
    fval = 1'b0; dval = 1'b0;
    step(1);
    check("rmid_fcnt", frame_cnt, 0);
    check("rmid_bank", hist_bank, 0);
    check("rmid_sv", stats_valid, 0);
    check("rmid_ovr", clr_overrun, 0);
    exp_bank = 1'b0;
    exp_cnt  = 0;
    frame("r1", 300, -1, 1'b1, NPIX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
